// File: rtl/temp_pkg.sv
// Shared types and constants for the LM75-word to BCD temperature converter.
// Used by temp_bcd_convert; the limits only matter when TEMP_RANGE_CHECK_EN is defined.
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int RAW_MSB = 15;
  localparam int RAW_LSB = 7;
  localparam int RAW_W   = RAW_MSB - RAW_LSB + 1;

  // Signed limits in half-degree units (+125.0 C and -55.0 C)
  localparam int TEMP_MAX_HALF = 250;
  localparam int TEMP_MIN_HALF = -110;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration on {bcd[11:0], bin[7:0]}: add 3 to every BCD
// nibble that is 5 or more, then shift the whole vector left by one.
module bcd_dabble_step (
  input  logic [19:0] i_vec,
  output logic [19:0] o_vec
);

  logic [19:0] w_adj;

  always_comb begin
    w_adj = i_vec;
    for (int n = 0; n < 3; n++) begin
      if (i_vec[8+4*n +: 4] >= 4'd5) begin
        w_adj[8+4*n +: 4] = i_vec[8+4*n +: 4] + 4'd3;
      end
    end
  end

  assign o_vec = {w_adj[18:0], 1'b0};

endmodule

// File: rtl/temp_bcd_convert.sv
// Stability-filters the LM75 temperature word and converts it to sign, three BCD
// digits and a half-degree digit. Optional clamping/range_err: TEMP_RANGE_CHECK_EN.
module temp_bcd_convert
  import temp_pkg::*;
#(
  parameter int STABLE_CYCLES = 512,
  parameter int CNT_W         = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_temp_raw,
  output logic        o_sign,
  output logic [3:0]  o_bcd_hund,
  output logic [3:0]  o_bcd_tens,
  output logic [3:0]  o_bcd_ones,
  output logic [3:0]  o_bcd_frac,
  output logic        o_valid,
`ifdef TEMP_RANGE_CHECK_EN
  output logic        o_range_err,
`endif
  output logic        o_busy
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  state_t             r_state;
  state_t             w_stateNext;
  logic [RAW_W-1:0]   r_prevRaw;
  logic [RAW_W-1:0]   r_lastConv;
  logic [CNT_W-1:0]   r_stabCnt;
  logic [2:0]         r_iter;
  logic [19:0]        r_shiftReg;
  logic               r_signPend;
  logic               r_fracPend;
  logic               r_errPend;
  logic               r_sign;
  logic [3:0]         r_hund;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [3:0]         r_frac;
  logic               r_valid;
  logic               r_rangeErr;

  logic [RAW_W-1:0]   w_raw;
  logic [RAW_W-1:0]   w_samp;
  logic [RAW_W-1:0]   w_mag;
  logic               w_clampErr;
  logic               w_start;
  logic [19:0]        w_stepOut;
  logic               w_unused_lsbs;

  assign w_raw         = i_temp_raw[RAW_MSB:RAW_LSB];
  assign w_unused_lsbs = ^i_temp_raw[RAW_LSB-1:0];
  assign w_start       = (r_state == IDLE) && (r_stabCnt == STABLE_CNT) && (r_prevRaw != r_lastConv);

  // Sample to convert; with range checking it is clamped before the magnitude is taken
  always_comb begin
    w_samp     = r_prevRaw;
    w_clampErr = 1'b0;
`ifdef TEMP_RANGE_CHECK_EN
    if (int'($signed(r_prevRaw)) > TEMP_MAX_HALF) begin
      w_samp     = RAW_W'(TEMP_MAX_HALF);
      w_clampErr = 1'b1;
    end else if (int'($signed(r_prevRaw)) < TEMP_MIN_HALF) begin
      w_samp     = RAW_W'(TEMP_MIN_HALF);
      w_clampErr = 1'b1;
    end
`endif
  end

  assign w_mag = w_samp[RAW_W-1] ? ((~w_samp) + 1'b1) : w_samp;

  bcd_dabble_step u_step (
    .i_vec (r_shiftReg),
    .o_vec (w_stepOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_start) w_stateNext = SHIFT;
      SHIFT:   if (r_iter == 3'd7) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Filter runs every clock regardless of state; last_conv keeps mid-conversion changes pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevRaw  <= '0;
      r_lastConv <= '0;
      r_stabCnt  <= '0;
      r_iter     <= '0;
      r_shiftReg <= '0;
      r_signPend <= 1'b0;
      r_fracPend <= 1'b0;
      r_errPend  <= 1'b0;
      r_sign     <= 1'b0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_frac     <= '0;
      r_valid    <= 1'b0;
      r_rangeErr <= 1'b0;
    end else begin
      r_prevRaw <= w_raw;
      if (w_raw != r_prevRaw) begin
        r_stabCnt <= '0;
      end else if (r_stabCnt != STABLE_CNT) begin
        r_stabCnt <= r_stabCnt + CNT_W'(1);
      end
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_lastConv <= r_prevRaw;
            r_shiftReg <= {12'd0, w_mag[RAW_W-1:1]};
            r_fracPend <= w_mag[0];
            r_signPend <= w_samp[RAW_W-1];
            r_errPend  <= w_clampErr;
            r_iter     <= '0;
          end
        end
        SHIFT: begin
          r_shiftReg <= w_stepOut;
          r_iter     <= r_iter + 3'd1;
        end
        DONE: begin
          r_sign     <= r_signPend;
          r_hund     <= r_shiftReg[19:16];
          r_tens     <= r_shiftReg[15:12];
          r_ones     <= r_shiftReg[11:8];
          r_frac     <= r_fracPend ? 4'd5 : 4'd0;
          r_rangeErr <= r_errPend;
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_sign     = r_sign;
  assign o_bcd_hund = r_hund;
  assign o_bcd_tens = r_tens;
  assign o_bcd_ones = r_ones;
  assign o_bcd_frac = r_frac;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state != IDLE);
`ifdef TEMP_RANGE_CHECK_EN
  assign o_range_err = r_rangeErr;
`else
  logic w_unused_err;
  assign w_unused_err = r_rangeErr ^ r_errPend;
`endif

endmodule

// File: tb/tb_temp_bcd_convert.sv
// Scoreboard bench for temp_bcd_convert: expected results are queued when a word is
// driven and checked when valid pulses. Also builds with TEMP_RANGE_CHECK_EN defined.
module tb_temp_bcd_convert;

  localparam int STABLE = 512;

  typedef struct packed {
    logic       rangeErr;
    logic       sign;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] frac;
  } result_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tempRaw = 16'h0000;
  logic        sign;
  logic [3:0]  bcdHund, bcdTens, bcdOnes, bcdFrac;
  logic        valid, busy;
  logic        rangeErr;

  result_t expQ[$];
  result_t monExp;
  int total = 0;
  int bad = 0;
  int validCount = 0;
  int busyRun = 0;

  temp_bcd_convert #(.STABLE_CYCLES(STABLE), .CNT_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_temp_raw (tempRaw),
    .o_sign     (sign),
    .o_bcd_hund (bcdHund),
    .o_bcd_tens (bcdTens),
    .o_bcd_ones (bcdOnes),
    .o_bcd_frac (bcdFrac),
    .o_valid    (valid),
`ifdef TEMP_RANGE_CHECK_EN
    .o_range_err(rangeErr),
`endif
    .o_busy     (busy)
  );

`ifndef TEMP_RANGE_CHECK_EN
  assign rangeErr = 1'b0;
`endif

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // Arithmetic reference: signed half-degrees to decimal digits
  function automatic result_t model(input logic [15:0] raw);
    result_t r;
    logic signed [8:0] s;
    int v, mag, ip;
    r = '0;
    s = raw[15:7];
    v = s;
`ifdef TEMP_RANGE_CHECK_EN
    if (v > 250) begin
      v = 250;
      r.rangeErr = 1'b1;
    end else if (v < -110) begin
      v = -110;
      r.rangeErr = 1'b1;
    end
`endif
    r.sign = (v < 0);
    mag    = (v < 0) ? -v : v;
    ip     = mag / 2;
    r.hund = 4'(ip / 100);
    r.tens = 4'((ip / 10) % 10);
    r.ones = 4'(ip % 10);
    r.frac = (mag % 2 != 0) ? 4'd5 : 4'd0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      validCount++;
      checkOutput("busy_before_valid", busyRun, 9);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sign", int'(sign), int'(monExp.sign));
        checkOutput("hund", int'(bcdHund), int'(monExp.hund));
        checkOutput("tens", int'(bcdTens), int'(monExp.tens));
        checkOutput("ones", int'(bcdOnes), int'(monExp.ones));
        checkOutput("frac", int'(bcdFrac), int'(monExp.frac));
`ifdef TEMP_RANGE_CHECK_EN
        checkOutput("range_err", int'(rangeErr), int'(monExp.rangeErr));
`endif
      end
    end
    busyRun = busy ? busyRun + 1 : 0;
  end

  task automatic applyStimulus(input logic [15:0] raw, input bit expectConv, input int holdCycles);
    @(negedge clk);
    tempRaw = raw;
    if (expectConv) expQ.push_back(model(raw));
    repeat (holdCycles) @(negedge clk);
    if (expectConv) begin
      checkOutput($sformatf("pending_%h", raw), expQ.size(), 0);
      expQ.delete();
    end
  endtask

  task automatic checkCleared(input string prefix);
    checkOutput({prefix, "_sign"}, int'(sign), 0);
    checkOutput({prefix, "_hund"}, int'(bcdHund), 0);
    checkOutput({prefix, "_tens"}, int'(bcdTens), 0);
    checkOutput({prefix, "_ones"}, int'(bcdOnes), 0);
    checkOutput({prefix, "_frac"}, int'(bcdFrac), 0);
    checkOutput({prefix, "_valid"}, int'(valid), 0);
    checkOutput({prefix, "_busy"}, int'(busy), 0);
    checkOutput({prefix, "_rerr"}, int'(rangeErr), 0);
  endtask

  initial begin
    int v0, wait0, lat;
    repeat (3) @(negedge clk);
    checkCleared("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    v0 = validCount;
    applyStimulus(16'h1900, 1'b1, 600);
    checkOutput("valid_once", validCount - v0, 1);
    applyStimulus(16'hE700, 1'b1, 600);
    applyStimulus(16'hFF80, 1'b1, 600);
    applyStimulus(16'h7D00, 1'b1, 600);
`ifdef TEMP_RANGE_CHECK_EN
    applyStimulus(16'h7F80, 1'b1, 600);
    applyStimulus(16'hC800, 1'b1, 600);
`endif

    v0 = validCount;
    for (int i = 0; i < 25; i++) begin
      applyStimulus((i % 2 == 0) ? 16'h1900 : 16'h1980, 1'b0, 200);
    end
    checkOutput("toggle_valids", validCount - v0, 0);

    applyStimulus(16'h1900, 1'b1, 600);
    v0 = validCount;
    applyStimulus(16'h197F, 1'b0, 300);
    applyStimulus(16'h1955, 1'b0, 300);
    applyStimulus(16'h1901, 1'b0, 600);
    checkOutput("lowbits_valids", validCount - v0, 0);

    applyStimulus(16'h1980, 1'b1, 600);

    // Abort a conversion at iteration 4, then expect a clean reconversion
    v0 = validCount;
    @(negedge clk);
    tempRaw = 16'h1900;
    wait0 = 0;
    while (!busy && wait0 < 700) begin
      @(negedge clk);
      wait0++;
    end
    checkOutput("abort_busy_seen", int'(busy), 1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCleared("abort");
    repeat (5) @(negedge clk);
    checkCleared("abort_hold");
    expQ.push_back(model(16'h1900));
    rst_n = 1'b1;
    lat = 0;
    while (!valid && lat < 700) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("reconv_latency_ok", int'(lat >= STABLE + 9 && lat <= STABLE + 11), 1);
    repeat (3) @(negedge clk);
    checkOutput("reconv_pending", expQ.size(), 0);
    checkOutput("abort_valids", validCount - v0, 1);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
